// File: rtl/udl_bounce_cnt.sv
// Up/down/loadable counter over the window [MIN_VAL, MAX_VAL] with wrap, saturate,
// bounce (ping-pong) and hold modes, plus a terminal-count flag and effective direction.
module udl_bounce_cnt #(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d_nu,
    input  logic             pl,
    input  logic [WIDTH-1:0] pin,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] cnt,
    output logic             dir,
    output logic             tc
);

    generate
        if (WIDTH < 2 || MIN_VAL < 0 || MIN_VAL > MAX_VAL ||
            longint'(MAX_VAL) > ((longint'(1) << WIDTH) - longint'(1))) begin : g_bad_param
            $error("udl_bounce_cnt: need WIDTH>=2 and 0 <= MIN_VAL <= MAX_VAL <= 2^WIDTH-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        MODE_WRAP   = 2'b00,
        MODE_SAT    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [WIDTH:0] L_MIN = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0] L_MAX = (WIDTH+1)'(MAX_VAL);

    // One guard bit above the bus keeps +/-1 at 0 or 2^WIDTH-1 from aliasing.
    logic [WIDTH:0] r_cnt;
    dir_e           r_dir;

    logic [WIDTH:0] w_cnt_nxt;
    dir_e           w_dir_nxt;
    logic [WIDTH:0] w_pin_x;
    logic [WIDTH:0] w_clamp;
    logic [WIDTH:0] w_inc;
    logic [WIDTH:0] w_dec;
    logic           w_at_max;
    logic           w_at_min;
    mode_e          w_mode;
    logic           w_dir;

    assign w_mode   = mode_e'(mode);
    assign w_pin_x  = {1'b0, pin};
    assign w_clamp  = (w_pin_x < L_MIN) ? L_MIN : ((w_pin_x > L_MAX) ? L_MAX : w_pin_x);
    assign w_inc    = r_cnt + 1'b1;
    assign w_dec    = r_cnt - 1'b1;
    assign w_at_max = (r_cnt == L_MAX);
    assign w_at_min = (r_cnt == L_MIN);

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        if (pl) begin
            w_cnt_nxt = w_clamp;
            w_dir_nxt = dir_e'(d_nu);
        end else begin
            // Track the commanded direction so a later switch to bounce starts that way.
            if (w_mode == MODE_WRAP || w_mode == MODE_SAT) begin
                w_dir_nxt = dir_e'(d_nu);
            end
            if (en) begin
                case (w_mode)
                    MODE_WRAP: begin
                        if (!d_nu) w_cnt_nxt = w_at_max ? L_MIN : w_inc;
                        else       w_cnt_nxt = w_at_min ? L_MAX : w_dec;
                    end
                    MODE_SAT: begin
                        if (!d_nu) w_cnt_nxt = w_at_max ? r_cnt : w_inc;
                        else       w_cnt_nxt = w_at_min ? r_cnt : w_dec;
                    end
                    MODE_BOUNCE: begin
                        // A single-value window has nowhere to go; count and direction stay put.
                        if (L_MIN != L_MAX) begin
                            if (r_dir == DIR_UP) begin
                                w_cnt_nxt = w_at_max ? w_dec : w_inc;
                                if (w_at_max) w_dir_nxt = DIR_DOWN;
                            end else begin
                                w_cnt_nxt = w_at_min ? w_inc : w_dec;
                                if (w_at_min) w_dir_nxt = DIR_UP;
                            end
                        end
                    end
                    default: begin
                        w_cnt_nxt = r_cnt;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= L_MIN;
            r_dir <= DIR_UP;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_dir <= w_dir_nxt;
        end
    end

    assign w_dir = (w_mode == MODE_BOUNCE) ? r_dir : d_nu;
    assign cnt   = r_cnt[WIDTH-1:0];
    assign dir   = w_dir;
    assign tc    = en && !pl && (w_mode != MODE_HOLD) &&
                   ((!w_dir && w_at_max) || (w_dir && w_at_min));

endmodule
